// File: rtl/sseg_pkg.sv
// Shared constants and types for the seven-segment capture path.
// Segment vectors are indexed [0:6] so bit 0 is segment a, matching the bus.
package sseg_pkg;

  localparam logic [0:6] SEG_0     = 7'b0000001;
  localparam logic [0:6] SEG_1     = 7'b1001111;
  localparam logic [0:6] SEG_2     = 7'b0010010;
  localparam logic [0:6] SEG_3     = 7'b0000110;
  localparam logic [0:6] SEG_4     = 7'b1001100;
  localparam logic [0:6] SEG_5     = 7'b0100100;
  localparam logic [0:6] SEG_6     = 7'b0100000;
  localparam logic [0:6] SEG_7     = 7'b0001111;
  localparam logic [0:6] SEG_8     = 7'b0000000;
  localparam logic [0:6] SEG_9     = 7'b0000100;
  localparam logic [0:6] SEG_A     = 7'b0001000;
  localparam logic [0:6] SEG_B     = 7'b1100000;
  localparam logic [0:6] SEG_C     = 7'b0110001;
  localparam logic [0:6] SEG_D     = 7'b1000010;
  localparam logic [0:6] SEG_E     = 7'b0110000;
  localparam logic [0:6] SEG_F     = 7'b0111000;
  localparam logic [0:6] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    KIND_GLYPH   = 2'd0,
    KIND_BLANK   = 2'd1,
    KIND_UNKNOWN = 2'd2
  } seg_kind_e;

  typedef struct packed {
    seg_kind_e  kind;
    logic [3:0] nibble;
  } seg_decode_t;

endpackage

// File: rtl/sseg_glyph_decode.sv
// Combinational reverse lookup: active-low segment pattern to hex nibble.
// Patterns outside the glyph table and not blank are flagged as unknown.
module sseg_glyph_decode
  import sseg_pkg::*;
(
  input  logic [0:6]  pattern,
  output seg_decode_t result
);

  always_comb begin
    result.kind   = KIND_GLYPH;
    result.nibble = 4'h0;
    case (pattern)
      SEG_0:     result.nibble = 4'h0;
      SEG_1:     result.nibble = 4'h1;
      SEG_2:     result.nibble = 4'h2;
      SEG_3:     result.nibble = 4'h3;
      SEG_4:     result.nibble = 4'h4;
      SEG_5:     result.nibble = 4'h5;
      SEG_6:     result.nibble = 4'h6;
      SEG_7:     result.nibble = 4'h7;
      SEG_8:     result.nibble = 4'h8;
      SEG_9:     result.nibble = 4'h9;
      SEG_A:     result.nibble = 4'hA;
      SEG_B:     result.nibble = 4'hB;
      SEG_C:     result.nibble = 4'hC;
      SEG_D:     result.nibble = 4'hD;
      SEG_E:     result.nibble = 4'hE;
      SEG_F:     result.nibble = 4'hF;
      SEG_BLANK: result.kind   = KIND_BLANK;
      default:   result.kind   = KIND_UNKNOWN;
    endcase
  end

endmodule

// File: rtl/sseg_scan_capture.sv
// Samples a multiplexed active-low seven-segment bus, waits for each
// strobe/pattern pair to settle, and rebuilds the displayed hex word.
module sseg_scan_capture
  import sseg_pkg::*;
#(
  parameter int NUM_DIGITS    = 8,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [0:6]              SSeg,
  input  logic [NUM_DIGITS-1:0]   an,
  output logic [4*NUM_DIGITS-1:0] value,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic                    frame_done,
  output logic                    err
);

  localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYCLES);

  logic [NUM_DIGITS-1:0]   an_reg;
  logic [0:6]              seg_reg;
  logic [7:0]              cnt_reg, cnt_next;
  logic [NUM_DIGITS-1:0]   seen_reg, seen_next, seen_acc;
  logic [NUM_DIGITS-1:0]   sel_mask;
  logic [4*NUM_DIGITS-1:0] value_next;
  logic [NUM_DIGITS-1:0]   digit_valid_next;
  logic                    changed, one_hot, accept, frame_hit, err_next;
  seg_decode_t             dec;

  sseg_glyph_decode u_decode (
    .pattern (seg_reg),
    .result  (dec)
  );

  assign changed  = (an != an_reg) || (SSeg != seg_reg);
  assign cnt_next = changed ? 8'd1 :
                    (cnt_reg == STABLE_MAX) ? STABLE_MAX : cnt_reg + 8'd1;

  assign sel_mask = ~an_reg;
  assign one_hot  = $onehot(sel_mask);
  // Accept only on the transition into saturation, so a held pair fires once.
  assign accept   = !changed && (cnt_reg == STABLE_MAX - 8'd1) && one_hot;

  assign seen_acc  = seen_reg | (accept ? sel_mask : '0);
  assign frame_hit = &seen_acc;
  assign seen_next = frame_hit ? '0 : seen_acc;
  assign err_next  = accept && (dec.kind == KIND_UNKNOWN);

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    logic hit;
    assign hit = accept && sel_mask[gi];
    assign value_next[4*gi +: 4] = (hit && dec.kind == KIND_GLYPH) ?
                                   dec.nibble : value[4*gi +: 4];
    assign digit_valid_next[gi]  = hit ? (dec.kind == KIND_GLYPH) : digit_valid[gi];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_reg      <= '1;
      seg_reg     <= '1;
      cnt_reg     <= 8'd0;
      seen_reg    <= '0;
      value       <= '0;
      digit_valid <= '0;
      frame_done  <= 1'b0;
      err         <= 1'b0;
    end else begin
      an_reg      <= an;
      seg_reg     <= SSeg;
      cnt_reg     <= cnt_next;
      seen_reg    <= seen_next;
      value       <= value_next;
      digit_valid <= digit_valid_next;
      frame_done  <= frame_hit;
      err         <= err_next;
    end
  end

endmodule
